bram_march_ctrl: RTL and testbench

- Self-test sequencer for one true-dual-port block RAM (bram_tdp, registered read, 1-cycle latency).
- Runs a four-element March test over addresses 0..ADDR_LAST: writes go through port A, reads through port B.
- Compares every read, counts mismatches and reports pass/fail to the power-analysis harness.
- Instantiated next to bram_tdp, in place of free-running toggle stimulus, when functional coverage of the memory is required.

---
 rtl/bram_march_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_bram_march_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_march_ctrl.sv
// March self-test sequencer for a true-dual-port BRAM: writes through port A,
// reads through port B (1-cycle read latency), counts and locates mismatches.
module bram_march_ctrl #(
  parameter int              AW        = 17,
  parameter int              DW        = 8,
  parameter int unsigned     ADDR_LAST = 2**AW-1,
  parameter logic [DW-1:0]   PAT       = 8'hA6,
  parameter int              ID        = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic          en_a,
  output logic          we_a,
  output logic [AW-1:0] addr_a,
  output logic [DW-1:0] din_a,
  output logic          en_b,
  output logic [AW-1:0] addr_b,
  input  logic [DW-1:0] dout_b
);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, DRAIN, FIN} state_e;

  localparam logic [AW-1:0] LAST = AW'(ADDR_LAST);

  // ID only tags an instance for simulation tooling; it carries no hardware.
  if (ID < 0) begin : g_id_tag
  end

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          phase_q, phase_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [15:0]   err_q, err_d;
  logic [AW-1:0] ferr_q, ferr_d;

  logic          en_a_q, en_a_d;
  logic          we_a_q, we_a_d;
  logic [AW-1:0] addr_a_q, addr_a_d;
  logic [DW-1:0] din_a_q, din_a_d;
  logic          en_b_q, en_b_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [DW-1:0] exp_b_q, exp_b_d;

  // Read-return stage: describes the data arriving on dout_b this cycle.
  logic          rd_vld_q;
  logic [AW-1:0] rd_addr_q;
  logic [DW-1:0] rd_exp_q;
  logic          mismatch;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    phase_d  = phase_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    done_d   = 1'b0;
    mismatch = rd_vld_q && (dout_b != rd_exp_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = M0;
          addr_d  = '0;
          phase_d = 1'b0;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
        end
      end
      M0: begin
        if (addr_q == LAST) begin
          state_d = M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      M1: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (addr_q == LAST) begin
            state_d = M2;
            addr_d  = LAST;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      M2: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (addr_q == '0) begin
            state_d = M3;
            addr_d  = '0;
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end
      end
      M3: begin
        if (addr_q == LAST) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: state_d = FIN;
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        pass_d  = (err_q == 16'd0);
      end
      default: state_d = IDLE;
    endcase

    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0)    ferr_d = rd_addr_q;
    end

    busy_d = (state_d != IDLE);

    // Port commands are derived from the upcoming state so the registered
    // outputs line up with the cycle that state occupies.
    en_a_d   = 1'b0;
    we_a_d   = 1'b0;
    en_b_d   = 1'b0;
    addr_a_d = addr_a_q;
    din_a_d  = din_a_q;
    addr_b_d = addr_b_q;
    exp_b_d  = exp_b_q;
    case (state_d)
      M0: begin
        en_a_d   = 1'b1;
        we_a_d   = 1'b1;
        addr_a_d = addr_d;
        din_a_d  = PAT;
      end
      M1, M2: begin
        if (!phase_d) begin
          en_b_d   = 1'b1;
          addr_b_d = addr_d;
          exp_b_d  = (state_d == M1) ? PAT : ~PAT;
        end else begin
          en_a_d   = 1'b1;
          we_a_d   = 1'b1;
          addr_a_d = addr_d;
          din_a_d  = (state_d == M1) ? ~PAT : PAT;
        end
      end
      M3: begin
        en_b_d   = 1'b1;
        addr_b_d = addr_d;
        exp_b_d  = PAT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ferr_q    <= '0;
      en_a_q    <= 1'b0;
      we_a_q    <= 1'b0;
      addr_a_q  <= '0;
      din_a_q   <= '0;
      en_b_q    <= 1'b0;
      addr_b_q  <= '0;
      exp_b_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_exp_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      en_a_q    <= en_a_d;
      we_a_q    <= we_a_d;
      addr_a_q  <= addr_a_d;
      din_a_q   <= din_a_d;
      en_b_q    <= en_b_d;
      addr_b_q  <= addr_b_d;
      exp_b_q   <= exp_b_d;
      rd_vld_q  <= en_b_q;
      rd_addr_q <= addr_b_q;
      rd_exp_q  <= exp_b_q;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;
  assign en_a           = en_a_q;
  assign we_a           = we_a_q;
  assign addr_a         = addr_a_q;
  assign din_a          = din_a_q;
  assign en_b           = en_b_q;
  assign addr_b         = addr_b_q;

endmodule

// File: tb/tb_bram_march_ctrl.sv
// Directed bench for bram_march_ctrl: 16-entry BRAM model with injectable
// stuck-bit faults, plus a one-entry instance for the ADDR_LAST=0 corner.
module tb_bram_march_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [7:0] PAT = 8'hA6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;

  logic          busy, done, pass, en_a, we_a, en_b;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr, addr_a, addr_b;
  logic [DW-1:0] din_a, dout_b;

  logic          busy1, done1, pass1, en_a1, we_a1, en_b1;
  logic [15:0]   err_cnt1;
  logic [AW-1:0] first_err_addr1, addr_a1, addr_b1;
  logic [DW-1:0] din_a1, dout_b1;

  logic [7:0] mem     [0:15];
  logic [7:0] andMask [0:15];
  logic [7:0] orMask  [0:15];
  logic [7:0] mem1;
  int collisions = 0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bram_march_ctrl #(.AW(AW), .DW(DW), .ADDR_LAST(15), .PAT(PAT), .ID(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .en_b(en_b), .addr_b(addr_b), .dout_b(dout_b)
  );

  bram_march_ctrl #(.AW(AW), .DW(DW), .ADDR_LAST(0), .PAT(PAT), .ID(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1), .first_err_addr(first_err_addr1),
    .en_a(en_a1), .we_a(we_a1), .addr_a(addr_a1), .din_a(din_a1),
    .en_b(en_b1), .addr_b(addr_b1), .dout_b(dout_b1)
  );

  // Faults are applied as the word is stored, like a defective cell would.
  always @(posedge clk) begin
    if (en_a && we_a) mem[addr_a] <= (din_a & andMask[addr_a]) | orMask[addr_a];
    if (en_b) dout_b <= mem[addr_b];
    if (en_a && en_b && addr_a == addr_b) collisions <= collisions + 1;
  end

  always @(posedge clk) begin
    if (en_a1 && we_a1) mem1 <= din_a1;
    if (en_b1) dout_b1 <= mem1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_faults();
    for (int i = 0; i < 16; i++) begin
      andMask[i] = 8'hFF;
      orMask[i]  = 8'h00;
    end
  endtask

  // Pulses start; edge 0 is the accepting edge. Returns the edge index at
  // which done was seen (-1 on timeout) and how many busy-low samples occurred.
  task automatic run_march(input int extraStart, output int doneEdge, output int busyGaps);
    doneEdge = -1;
    busyGaps = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (busy !== 1'b1) busyGaps++;
    for (int k = 1; k <= 150; k++) begin
      if (extraStart != 0 && k == extraStart) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (done === 1'b1) begin
        doneEdge = k;
        break;
      end
      if (busy !== 1'b1) busyGaps++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      checks++; if (pass !== 1'b0) begin fails++; $display("[TB] FAIL reset_pass: got %b want 0", pass); end
      checks++; if (err_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_err: got %0d want 0", err_cnt); end
      checks++; if (first_err_addr !== 4'd0) begin fails++; $display("[TB] FAIL reset_first: got %0d want 0", first_err_addr); end
      checks++; if ({en_a, we_a, en_b} !== 3'b000) begin fails++; $display("[TB] FAIL reset_en: got %b want 000", {en_a, we_a, en_b}); end
      checks++; if ({addr_a, addr_b, din_a} !== 16'h0000) begin fails++; $display("[TB] FAIL reset_addr_data: got %h want 0000", {addr_a, addr_b, din_a}); end
    end
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++; if ({en_a, en_b, busy, en_a1, en_b1} !== 5'b0) begin fails++; $display("[TB] FAIL idle_activity: got %b want 00000", {en_a, en_b, busy, en_a1, en_b1}); end
    end
  endtask

  task automatic test_clean();
    int doneEdge, busyGaps, badLocs;
    clear_faults();
    run_march(0, doneEdge, busyGaps);
    checks++; if (doneEdge !== 98) begin fails++; $display("[TB] FAIL clean_done_edge: got %0d want 98", doneEdge); end
    checks++; if (busyGaps !== 0) begin fails++; $display("[TB] FAIL clean_busy_gaps: got %0d want 0", busyGaps); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL clean_busy_end: got %b want 0", busy); end
    checks++; if (pass !== 1'b1) begin fails++; $display("[TB] FAIL clean_pass: got %b want 1", pass); end
    checks++; if (err_cnt !== 16'd0) begin fails++; $display("[TB] FAIL clean_err: got %0d want 0", err_cnt); end
    checks++; if (first_err_addr !== 4'd0) begin fails++; $display("[TB] FAIL clean_first: got %0d want 0", first_err_addr); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL clean_done_pulse: got %b want 0", done); end
    badLocs = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== PAT) badLocs++;
    checks++; if (badLocs !== 0) begin fails++; $display("[TB] FAIL clean_mem_final: got %0d bad locations want 0", badLocs); end
    checks++; if (collisions !== 0) begin fails++; $display("[TB] FAIL port_collision: got %0d want 0", collisions); end
  endtask

  task automatic test_stuck_at();
    int doneEdge, busyGaps;
    clear_faults();
    andMask[5] = 8'hFE;
    run_march(0, doneEdge, busyGaps);
    checks++; if (doneEdge !== 98) begin fails++; $display("[TB] FAIL stuck_done_edge: got %0d want 98", doneEdge); end
    checks++; if (err_cnt !== 16'd1) begin fails++; $display("[TB] FAIL stuck_err: got %0d want 1", err_cnt); end
    checks++; if (first_err_addr !== 4'd5) begin fails++; $display("[TB] FAIL stuck_first: got %0d want 5", first_err_addr); end
    checks++; if (pass !== 1'b0) begin fails++; $display("[TB] FAIL stuck_pass: got %b want 0", pass); end
  endtask

  // Address 12 reads 00 in M1, M2 and M3 (3 errors); address 3 only fails in
  // M2 (1 error). The ascending M1 pass reaches 12 first, so 12 is latched.
  task automatic test_multi_fault();
    int doneEdge, busyGaps;
    clear_faults();
    orMask[3]   = 8'h80;
    andMask[12] = 8'h00;
    run_march(0, doneEdge, busyGaps);
    checks++; if (doneEdge !== 98) begin fails++; $display("[TB] FAIL multi_done_edge: got %0d want 98", doneEdge); end
    checks++; if (err_cnt !== 16'd4) begin fails++; $display("[TB] FAIL multi_err: got %0d want 4", err_cnt); end
    checks++; if (first_err_addr !== 4'd12) begin fails++; $display("[TB] FAIL multi_first: got %0d want 12", first_err_addr); end
    checks++; if (pass !== 1'b0) begin fails++; $display("[TB] FAIL multi_pass: got %b want 0", pass); end
  endtask

  task automatic test_back_to_back();
    int doneEdge, busyGaps;
    clear_faults();
    run_march(20, doneEdge, busyGaps);
    checks++; if (doneEdge !== 98) begin fails++; $display("[TB] FAIL b2b_done_edge: got %0d want 98", doneEdge); end
    checks++; if (busyGaps !== 0) begin fails++; $display("[TB] FAIL b2b_busy_gaps: got %0d want 0", busyGaps); end
    checks++; if (pass !== 1'b1) begin fails++; $display("[TB] FAIL b2b_pass: got %b want 1", pass); end
    checks++; if (err_cnt !== 16'd0) begin fails++; $display("[TB] FAIL b2b_err_cleared: got %0d want 0", err_cnt); end
    checks++; if (first_err_addr !== 4'd0) begin fails++; $display("[TB] FAIL b2b_first_cleared: got %0d want 0", first_err_addr); end
  endtask

  task automatic test_reset_mid();
    int doneEdge, busyGaps, doneSeen;
    clear_faults();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (39) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL midrst_done: got %b want 0", done); end
    checks++; if ({en_a, we_a, en_b} !== 3'b000) begin fails++; $display("[TB] FAIL midrst_en: got %b want 000", {en_a, we_a, en_b}); end
    doneSeen = 0;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || en_a !== 1'b0 || en_b !== 1'b0) doneSeen++;
    end
    checks++; if (doneSeen !== 0) begin fails++; $display("[TB] FAIL midrst_quiet: got %0d active cycles want 0", doneSeen); end
    run_march(0, doneEdge, busyGaps);
    checks++; if (doneEdge !== 98) begin fails++; $display("[TB] FAIL midrst_rerun_edge: got %0d want 98", doneEdge); end
    checks++; if (pass !== 1'b1) begin fails++; $display("[TB] FAIL midrst_rerun_pass: got %b want 1", pass); end
  endtask

  task automatic test_addr_last_zero();
    int doneEdge;
    doneEdge = -1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done1 === 1'b1) begin
        doneEdge = k;
        break;
      end
    end
    checks++; if (doneEdge !== 8) begin fails++; $display("[TB] FAIL n1_done_edge: got %0d want 8", doneEdge); end
    checks++; if (pass1 !== 1'b1) begin fails++; $display("[TB] FAIL n1_pass: got %b want 1", pass1); end
    checks++; if (err_cnt1 !== 16'd0) begin fails++; $display("[TB] FAIL n1_err: got %0d want 0", err_cnt1); end
    checks++; if (mem1 !== PAT) begin fails++; $display("[TB] FAIL n1_mem: got %h want %h", mem1, PAT); end
  endtask

  initial begin
    clear_faults();
    test_reset();
    test_clean();
    test_stuck_at();
    test_multi_fault();
    test_back_to_back();
    test_reset_mid();
    test_addr_last_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
